strait_bist_sequencer: RTL and testbench

Parametrised STRAIT BIST sequencer for the systolic-array test path.
- Replaces the fixed controller, address generator and comparator trio with one block.
- Steps through NUM_PATTERNS ROM addresses and drives scan, launch, capture and compare strobes to the array.
- Compares array results against expected values and keeps the verdict: saturating error count, first-fail address and pass/done status.
- Adds a transition-delay (TD) launch phase and a programmable scan length, which the fixed controller lacks.

---
 rtl/strait_bist_sequencer_pkg.sv | 33 +++
 rtl/strait_bist_sequencer_if.sv | 41 ++++
 rtl/strait_bist_sequencer_fail_logger.sv | 62 ++++++
 rtl/strait_bist_sequencer.sv | 157 +++++++++++++++
 tb/tb_strait_bist_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/strait_bist_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : strait_bist_pkg
// Brief    : Shared types and constants for the STRAIT BIST sequencer:
//            FSM state encoding, test-mode codes and the counter
//            saturation helper.
// Revision : 1.0 - initial release
// ============================================================================
package strait_bist_pkg;

    // Sequencer states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_COMPARE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // bist_mode codes; 2'b11 is reserved and behaves like idle.
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_SA   = 2'b01;
    localparam logic [1:0] MODE_TD   = 2'b10;

    // All-ones value of a counter 'width' bits wide (saturation ceiling).
    function automatic logic [31:0] sat_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/strait_bist_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : strait_bist_sequencer_if
// Brief     : Control, pattern data and verdict signals between the array
//             test path (master) and the BIST sequencer (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface strait_bist_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic              bist_en;
    logic [1:0]        bist_mode;
    logic [DATA_W-1:0] actual;
    logic [DATA_W-1:0] expected;
    logic [ADDR_W-1:0] addr;
    logic              scan_en;
    logic              launch_en;
    logic              capture_en;
    logic              compare_en;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  error_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic              fail_valid;

    modport master (
        output bist_en, bist_mode, actual, expected,
        input  addr, scan_en, launch_en, capture_en, compare_en,
               busy, done, pass, error_count, first_fail_addr, fail_valid
    );

    modport slave (
        input  bist_en, bist_mode, actual, expected,
        output addr, scan_en, launch_en, capture_en, compare_en,
               busy, done, pass, error_count, first_fail_addr, fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/strait_bist_sequencer_fail_logger.sv
`default_nettype none
// ============================================================================
// Module   : strait_fail_logger
// Brief    : Result comparator for the BIST sequencer. Counts mismatches
//            with saturation and remembers the first failing address.
// Revision : 1.0 - initial release
// ============================================================================
module strait_fail_logger
    import strait_bist_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_compare_en,
    input  wire logic [DATA_W-1:0] i_actual,
    input  wire logic [DATA_W-1:0] i_expected,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic [CNT_W-1:0]       o_error_count,
    output logic [ADDR_W-1:0]      o_first_fail_addr,
    output logic                   o_fail_valid
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0]  r_error_count;
    logic [ADDR_W-1:0] r_first_fail_addr;
    logic              r_fail_valid;
    logic              w_mismatch;

    assign w_mismatch = i_compare_en && (i_actual != i_expected);

    // Clear at run start; on a strobed mismatch bump the count and log the first address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error_count     <= '0;
            r_first_fail_addr <= '0;
            r_fail_valid      <= 1'b0;
        end else if (i_clear) begin
            r_error_count     <= '0;
            r_first_fail_addr <= '0;
            r_fail_valid      <= 1'b0;
        end else if (w_mismatch) begin
            if (r_error_count != c_cnt_max) begin
                r_error_count <= r_error_count + 1'b1;
            end
            if (!r_fail_valid) begin
                r_first_fail_addr <= i_addr;
                r_fail_valid      <= 1'b1;
            end
        end
    end

    assign o_error_count     = r_error_count;
    assign o_first_fail_addr = r_first_fail_addr;
    assign o_fail_valid      = r_fail_valid;

endmodule
`default_nettype wire

// File: rtl/strait_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : strait_bist_sequencer
// Brief    : STRAIT BIST sequencer. Walks NUM_PATTERNS ROM addresses,
//            drives scan/launch/capture/compare strobes (registered, one
//            cycle behind the state register) and keeps the run verdict.
// Options  : STRAIT_STOP_ON_FAIL_EN - when defined, the first mismatch
//            ends the run with addr held at the failing pattern.
// Revision : 1.0 - initial release
// ============================================================================
module strait_bist_sequencer
    import strait_bist_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int NUM_PATTERNS = 16,
    parameter int SCAN_LEN     = 4,
    parameter int CNT_W        = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    strait_bist_sequencer_if.slave bus
);

    localparam int                c_scan_w    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_LEN - 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_PATTERNS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic                r_mode_td;
    logic                r_scan_en;
    logic                r_launch_en;
    logic                r_capture_en;
    logic                r_compare_en;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                w_start;
    logic                w_busy_state;
    logic                w_scan_last;
    logic [CNT_W-1:0]    w_error_count;
    logic [ADDR_W-1:0]   w_first_fail_addr;
    logic                w_fail_valid;

    assign w_start      = (r_state == ST_IDLE) && bus.bist_en &&
                          ((bus.bist_mode == MODE_SA) || (bus.bist_mode == MODE_TD));
    assign w_busy_state = (r_state == ST_SCAN)    || (r_state == ST_LAUNCH) ||
                          (r_state == ST_CAPTURE) || (r_state == ST_COMPARE) ||
                          (r_state == ST_NEXT);
    assign w_scan_last  = (r_scan_cnt == c_scan_last);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; dropping bist_en in any busy state aborts to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_next = ST_SCAN;
            ST_SCAN:    if (w_scan_last) w_state_next = r_mode_td ? ST_LAUNCH : ST_CAPTURE;
            ST_LAUNCH:  w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_COMPARE;
            ST_COMPARE: w_state_next = ST_NEXT;
            ST_NEXT: begin
`ifdef STRAIT_STOP_ON_FAIL_EN
                // compare_en is high during NEXT, so this is the compared result.
                if (r_compare_en && (bus.actual != bus.expected)) w_state_next = ST_DONE;
                else
`endif
                if (r_addr == c_last_addr) w_state_next = ST_DONE;
                else                       w_state_next = ST_SCAN;
            end
            ST_DONE:    if (!bus.bist_en) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (w_busy_state && !bus.bist_en) begin
            w_state_next = ST_IDLE;
        end
    end

    // Address/scan counters, mode latch and registered strobes/status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_scan_cnt   <= '0;
            r_mode_td    <= 1'b0;
            r_scan_en    <= 1'b0;
            r_launch_en  <= 1'b0;
            r_capture_en <= 1'b0;
            r_compare_en <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode_td <= (bus.bist_mode == MODE_TD);
                r_addr    <= '0;
            end else if ((r_state == ST_NEXT) && (w_state_next == ST_SCAN)) begin
                r_addr <= r_addr + 1'b1;
            end

            if ((r_state == ST_SCAN) && !w_scan_last) r_scan_cnt <= r_scan_cnt + 1'b1;
            else                                      r_scan_cnt <= '0;

            // Gated by bist_en so an abort silences everything on the same edge.
            r_scan_en    <= bus.bist_en && (r_state == ST_SCAN);
            r_launch_en  <= bus.bist_en && (r_state == ST_LAUNCH);
            r_capture_en <= bus.bist_en && (r_state == ST_CAPTURE);
            r_compare_en <= bus.bist_en && (r_state == ST_COMPARE);
            r_busy       <= bus.bist_en && w_busy_state;
            r_done       <= bus.bist_en && (r_state == ST_DONE);

            if (w_start)                  r_pass <= 1'b0;
            else if (r_state == ST_DONE)  r_pass <= (w_error_count == '0);
        end
    end

    strait_fail_logger #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fail_logger (
        .clk               (clk),
        .rst               (reset),
        .i_clear           (w_start),
        .i_compare_en      (r_compare_en),
        .i_actual          (bus.actual),
        .i_expected        (bus.expected),
        .i_addr            (r_addr),
        .o_error_count     (w_error_count),
        .o_first_fail_addr (w_first_fail_addr),
        .o_fail_valid      (w_fail_valid)
    );

    assign bus.addr            = r_addr;
    assign bus.scan_en         = r_scan_en;
    assign bus.launch_en       = r_launch_en;
    assign bus.capture_en      = r_capture_en;
    assign bus.compare_en      = r_compare_en;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.error_count     = w_error_count;
    assign bus.first_fail_addr = w_first_fail_addr;
    assign bus.fail_valid      = w_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_strait_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_strait_bist_sequencer
// Brief    : Directed self-checking bench for strait_bist_sequencer with
//            default parameters plus a CNT_W=2 instance for saturation.
//            Honours STRAIT_STOP_ON_FAIL_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_strait_bist_sequencer
    import strait_bist_pkg::*;
;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    strait_bist_sequencer_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(8)) bus  ();
    strait_bist_sequencer_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(2)) bus2 ();

    logic [15:0] fail_mask;
    logic [15:0] fail_mask2;

    // ROM model: expected word per address, actual inverted where a fault is injected.
    assign bus.expected  = 16'hA500 ^ {12'h000, bus.addr};
    assign bus.actual    = fail_mask[bus.addr] ? ~bus.expected : bus.expected;
    assign bus2.expected = 16'h3C00 ^ {12'h000, bus2.addr};
    assign bus2.actual   = fail_mask2[bus2.addr] ? ~bus2.expected : bus2.expected;

    strait_bist_sequencer #(.DATA_W(16), .ADDR_W(4), .NUM_PATTERNS(16), .SCAN_LEN(4), .CNT_W(8))
        dut (.clk(clk), .reset(reset), .bus(bus));
    strait_bist_sequencer #(.DATA_W(16), .ADDR_W(4), .NUM_PATTERNS(16), .SCAN_LEN(4), .CNT_W(2))
        dut_c2 (.clk(clk), .reset(reset), .bus(bus2));

    // Strobe monitor for the main instance.
    int   n_scan, n_launch, n_capture, n_compare, n_launch_cap, n_overlap, n_busy;
    logic mon_clear;
    logic prev_launch;

    // Count strobe cycles and ordering/overlap violations of the previous cycle.
    always @(posedge clk) begin
        if (mon_clear) begin
            n_scan = 0; n_launch = 0; n_capture = 0; n_compare = 0;
            n_launch_cap = 0; n_overlap = 0; n_busy = 0; prev_launch = 1'b0;
        end else begin
            if (bus.scan_en)    n_scan++;
            if (bus.launch_en)  n_launch++;
            if (bus.capture_en) begin
                n_capture++;
                if (prev_launch) n_launch_cap++;
            end
            if (bus.compare_en) n_compare++;
            if (bus.busy)       n_busy++;
            if (int'(bus.scan_en) + int'(bus.launch_en) + int'(bus.capture_en) + int'(bus.compare_en) > 1)
                n_overlap++;
            prev_launch = bus.launch_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests a run; returns just after edge t (the edge sampling bist_en=1).
    task automatic start_run(input logic [1:0] mode);
        bus.bist_mode = mode;
        bus.bist_en   = 1'b1;
        mon_clear     = 1'b1;
        tick();
        mon_clear     = 1'b0;
    endtask

    // Counts edges after t until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic stop_run();
        bus.bist_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.bist_en = 1'b0;  bus.bist_mode = 2'b00;  fail_mask = '0;
        bus2.bist_en = 1'b0; bus2.bist_mode = 2'b00; fail_mask2 = '0;
        mon_clear = 1'b1;
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", bus.pass); end
        checks++; if (bus.addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.addr); end
        checks++; if ({bus.scan_en, bus.launch_en, bus.capture_en, bus.compare_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.scan_en, bus.launch_en, bus.capture_en, bus.compare_en}); end
        checks++; if ({bus.error_count, bus.first_fail_addr, bus.fail_valid} !== 13'd0) begin
            errors++; $display("FAIL reset_verdict: got %h expected 0", {bus.error_count, bus.first_fail_addr, bus.fail_valid}); end
        reset = 1'b0;
        mon_clear = 1'b0;
        tick();
    endtask

    task automatic test_idle_modes();
        logic [1:0] modes [2];
        modes[0] = 2'b11;
        modes[1] = 2'b00;
        for (int m = 0; m < 2; m++) begin
            bus.bist_mode = modes[m];
            bus.bist_en   = 1'b1;
            mon_clear = 1'b1; tick(); mon_clear = 1'b0;
            repeat (10) tick();
            checks++; if (n_busy !== 0) begin errors++; $display("FAIL idle_mode%0d_busy: got %0d busy cycles expected 0", m, n_busy); end
            checks++; if (n_scan + n_launch + n_capture + n_compare !== 0) begin
                errors++; $display("FAIL idle_mode%0d_strobes: got %0d strobe cycles expected 0", m, n_scan + n_launch + n_capture + n_compare); end
            checks++; if (bus.addr !== 4'd0) begin errors++; $display("FAIL idle_mode%0d_addr: got %0d expected 0", m, bus.addr); end
            bus.bist_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_sa_all_pass();
        int cyc;
        fail_mask = '0;
        start_run(MODE_SA);
        wait_done(cyc);
        checks++; if (cyc !== 113) begin errors++; $display("FAIL sa_done_time: got t+%0d expected t+113", cyc); end
        checks++; if (n_scan !== 64) begin errors++; $display("FAIL sa_scan_cycles: got %0d expected 64", n_scan); end
        checks++; if (n_launch !== 0) begin errors++; $display("FAIL sa_launch: got %0d expected 0", n_launch); end
        checks++; if (n_capture !== 16 || n_compare !== 16) begin
            errors++; $display("FAIL sa_cap_cmp: got %0d/%0d expected 16/16", n_capture, n_compare); end
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL sa_overlap: got %0d expected 0", n_overlap); end
        checks++; if (n_busy !== 112) begin errors++; $display("FAIL sa_busy_cycles: got %0d expected 112", n_busy); end
        checks++; if ({bus.pass, bus.busy, bus.fail_valid} !== 3'b100) begin
            errors++; $display("FAIL sa_status: got pass,busy,fv=%b expected 100", {bus.pass, bus.busy, bus.fail_valid}); end
        checks++; if (bus.error_count !== 8'd0) begin errors++; $display("FAIL sa_errcnt: got %0d expected 0", bus.error_count); end
        stop_run();
        checks++; if ({bus.done, bus.pass} !== 2'b01) begin
            errors++; $display("FAIL sa_after_idle: got done,pass=%b expected 01", {bus.done, bus.pass}); end
    endtask

    task automatic test_td_mode_change();
        int cyc;
        fail_mask = '0;
        start_run(MODE_TD);
        bus.bist_mode = MODE_SA;
        wait_done(cyc);
        checks++; if (cyc !== 129) begin errors++; $display("FAIL td_done_time: got t+%0d expected t+129", cyc); end
        checks++; if (n_launch !== 16) begin errors++; $display("FAIL td_launch: got %0d expected 16", n_launch); end
        checks++; if (n_launch_cap !== 16) begin errors++; $display("FAIL td_launch_order: got %0d expected 16", n_launch_cap); end
        checks++; if (n_scan !== 64 || n_overlap !== 0) begin
            errors++; $display("FAIL td_scan_overlap: got %0d/%0d expected 64/0", n_scan, n_overlap); end
        checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL td_pass: got %b expected 1", bus.pass); end
        stop_run();
    endtask

    task automatic test_sa_mismatch();
        int cyc;
        fail_mask = 16'h0208;
        start_run(MODE_SA);
        wait_done(cyc);
`ifdef STRAIT_STOP_ON_FAIL_EN
        checks++; if (cyc !== 29) begin errors++; $display("FAIL mm_done_time: got t+%0d expected t+29", cyc); end
        checks++; if (bus.error_count !== 8'd1) begin errors++; $display("FAIL mm_errcnt: got %0d expected 1", bus.error_count); end
`else
        checks++; if (cyc !== 113) begin errors++; $display("FAIL mm_done_time: got t+%0d expected t+113", cyc); end
        checks++; if (bus.error_count !== 8'd2) begin errors++; $display("FAIL mm_errcnt: got %0d expected 2", bus.error_count); end
`endif
        checks++; if (bus.first_fail_addr !== 4'd3) begin errors++; $display("FAIL mm_first_fail: got %0d expected 3", bus.first_fail_addr); end
        checks++; if ({bus.fail_valid, bus.pass} !== 2'b10) begin
            errors++; $display("FAIL mm_verdict: got fv,pass=%b expected 10", {bus.fail_valid, bus.pass}); end
        stop_run();
        fail_mask = '0;
    endtask

`ifdef STRAIT_STOP_ON_FAIL_EN
    task automatic test_stop_on_fail();
        int cyc;
        fail_mask = 16'h0004;
        start_run(MODE_SA);
        wait_done(cyc);
        checks++; if (cyc !== 22) begin errors++; $display("FAIL sof_done_time: got t+%0d expected t+22", cyc); end
        checks++; if (bus.addr !== 4'd2) begin errors++; $display("FAIL sof_addr: got %0d expected 2", bus.addr); end
        checks++; if ({bus.error_count, bus.pass} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL sof_verdict: got errcnt=%0d pass=%b expected 1,0", bus.error_count, bus.pass); end
        stop_run();
        fail_mask = '0;
    endtask
`endif

    task automatic test_saturate();
        int cyc;
        fail_mask2 = 16'hFFFF;
        bus2.bist_mode = MODE_SA;
        bus2.bist_en   = 1'b1;
        tick();
        cyc = 0;
        while (!bus2.done && cyc < 300) begin
            tick();
            cyc++;
        end
`ifdef STRAIT_STOP_ON_FAIL_EN
        checks++; if (cyc !== 8) begin errors++; $display("FAIL sat_done_time: got t+%0d expected t+8", cyc); end
        checks++; if (bus2.error_count !== 2'd1) begin errors++; $display("FAIL sat_errcnt: got %0d expected 1", bus2.error_count); end
`else
        checks++; if (cyc !== 113) begin errors++; $display("FAIL sat_done_time: got t+%0d expected t+113", cyc); end
        checks++; if (bus2.error_count !== 2'd3) begin errors++; $display("FAIL sat_errcnt: got %0d expected 3", bus2.error_count); end
`endif
        checks++; if (bus2.first_fail_addr !== 4'd0) begin errors++; $display("FAIL sat_first_fail: got %0d expected 0", bus2.first_fail_addr); end
        checks++; if ({bus2.fail_valid, bus2.pass} !== 2'b10) begin
            errors++; $display("FAIL sat_verdict: got fv,pass=%b expected 10", {bus2.fail_valid, bus2.pass}); end
        bus2.bist_en = 1'b0;
        tick();
        tick();
        fail_mask2 = '0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int k;
        fail_mask = '0;
        start_run(MODE_SA);
        k = 0;
        while (!(bus.addr == 4'd5 && bus.scan_en) && k < 200) begin
            tick();
            k++;
        end
        checks++; if (k >= 200) begin errors++; $display("FAIL rst_reach_addr5: got timeout expected scan of addr 5"); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.addr !== 4'd0) begin errors++; $display("FAIL rst_async_addr: got %0d expected 0", bus.addr); end
        checks++; if ({bus.busy, bus.scan_en, bus.done} !== 3'b000) begin
            errors++; $display("FAIL rst_async_status: got busy,scan,done=%b expected 000", {bus.busy, bus.scan_en, bus.done}); end
        reset = 1'b0;
        start_run(MODE_SA);
        wait_done(cyc);
        checks++; if (cyc !== 113) begin errors++; $display("FAIL rst_rerun_time: got t+%0d expected t+113", cyc); end
        checks++; if (n_scan !== 64 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL rst_rerun_result: got scan=%0d pass=%b expected 64,1", n_scan, bus.pass); end
        stop_run();
    endtask

    task automatic test_abort();
        int k;
        fail_mask = '0;
        start_run(MODE_SA);
        k = 0;
        while (bus.addr != 4'd7 && k < 200) begin
            tick();
            k++;
        end
        checks++; if (k >= 200) begin errors++; $display("FAIL abort_reach_addr7: got timeout expected addr 7"); end
        bus.bist_en = 1'b0;
        tick();
        checks++; if ({bus.busy, bus.scan_en, bus.launch_en, bus.capture_en, bus.compare_en} !== 5'b00000) begin
            errors++; $display("FAIL abort_next_cycle: got busy/strobes=%b expected 00000",
                               {bus.busy, bus.scan_en, bus.launch_en, bus.capture_en, bus.compare_en}); end
        repeat (3) tick();
        checks++; if ({bus.done, bus.pass, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL abort_status: got done,pass,busy=%b expected 000", {bus.done, bus.pass, bus.busy}); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        fail_mask = '0;
        start_run(MODE_SA);
        wait_done(cyc);
        checks++; if (cyc !== 113) begin errors++; $display("FAIL b2b_done_time: got t+%0d expected t+113", cyc); end
        checks++; if (n_compare !== 16 || bus.addr !== 4'd15) begin
            errors++; $display("FAIL b2b_walk: got compares=%0d addr=%0d expected 16,15", n_compare, bus.addr); end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_idle_modes();
        test_sa_all_pass();
        test_td_mode_change();
        test_sa_mismatch();
`ifdef STRAIT_STOP_ON_FAIL_EN
        test_stop_on_fail();
`endif
        test_saturate();
        test_reset_mid_run();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
